// File: rtl/control_sequencer.sv
// Microcoded control unit: steps the microinstruction counter, decodes opcode/step
// into the bus control word, and keeps the {C,Z} flags used by conditional jumps.
module control_sequencer #(
    parameter int unsigned STEPS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       carry,
    input  logic       zero,
    output logic       HLT,
    output logic       MI,
    output logic       RI,
    output logic       RO,
    output logic       IO,
    output logic       II,
    output logic       AI,
    output logic       AO,
    output logic       BI,
    output logic       BO,
    output logic       EO,
    output logic       SU,
    output logic       OI,
    output logic       CE,
    output logic       CO,
    output logic       J,
    output logic       FI,
    output logic [2:0] step,
    output logic [1:0] flags
);

    localparam int unsigned STEP_W = 3;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [STEP_W-1:0] step_next;
    logic [1:0]        flags_next;
    logic              halted;
    logic              halted_next;

    // State register: step counter, stored flags, halt latch
    always_ff @(posedge clk) begin
        if (!rst) begin
            step   <= '0;
            flags  <= 2'b00;
            halted <= 1'b0;
        end else begin
            step   <= step_next;
            flags  <= flags_next;
            halted <= halted_next;
        end
    end

    // Next state: counter wraps at STEPS-1; everything freezes once halted
    always_comb begin
        step_next   = step;
        flags_next  = flags;
        halted_next = halted;
        if (!halted) begin
            step_next = (step == LAST_STEP) ? '0 : step + STEP_W'(1);
            if (FI) flags_next = {carry, zero};
            if (HLT) halted_next = 1'b1;
        end
    end

    // Control word decode; reset forces an all-zero word regardless of state
    always_comb begin
        HLT = 1'b0; MI = 1'b0; RI = 1'b0; RO = 1'b0; IO = 1'b0; II = 1'b0;
        AI  = 1'b0; AO = 1'b0; BI = 1'b0; BO = 1'b0; EO = 1'b0; SU = 1'b0;
        OI  = 1'b0; CE = 1'b0; CO = 1'b0; J  = 1'b0; FI = 1'b0;
        if (rst) begin
            if (halted) begin
                HLT = 1'b1;
            end else begin
                case (step)
                    3'd0: begin CO = 1'b1; MI = 1'b1; end
                    3'd1: begin RO = 1'b1; II = 1'b1; CE = 1'b1; end
                    3'd2: begin
                        case (opcode)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin IO = 1'b1; MI = 1'b1; end
                            OP_LDI: begin IO = 1'b1; AI = 1'b1; end
                            OP_JMP: begin IO = 1'b1; J = 1'b1; end
                            OP_JC:  begin IO = flags[1]; J = flags[1]; end
                            OP_JZ:  begin IO = flags[0]; J = flags[0]; end
                            OP_OUT: begin AO = 1'b1; OI = 1'b1; end
                            OP_HLT: HLT = 1'b1;
                            default: ;
                        endcase
                    end
                    3'd3: begin
                        case (opcode)
                            OP_LDA:         begin RO = 1'b1; AI = 1'b1; end
                            OP_ADD, OP_SUB: begin RO = 1'b1; BI = 1'b1; end
                            OP_STA:         begin AO = 1'b1; RI = 1'b1; end
                            default: ;
                        endcase
                    end
                    3'd4: begin
                        if (opcode == OP_ADD || opcode == OP_SUB) begin
                            EO = 1'b1; AI = 1'b1; FI = 1'b1;
                            SU = (opcode == OP_SUB);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a microcode-ROM reference model predicts
// each cycle's control word, step and flags; a negedge monitor compares them.
module tb_control_sequencer;

    localparam int unsigned STEPS = 5;

    // Control word bit positions, order {HLT,MI,RI,RO,IO,II,AI,AO,BI,BO,EO,SU,OI,CE,CO,J,FI}
    localparam logic [16:0] C_HLT = 17'd1 << 16;
    localparam logic [16:0] C_MI  = 17'd1 << 15;
    localparam logic [16:0] C_RI  = 17'd1 << 14;
    localparam logic [16:0] C_RO  = 17'd1 << 13;
    localparam logic [16:0] C_IO  = 17'd1 << 12;
    localparam logic [16:0] C_II  = 17'd1 << 11;
    localparam logic [16:0] C_AI  = 17'd1 << 10;
    localparam logic [16:0] C_AO  = 17'd1 << 9;
    localparam logic [16:0] C_BI  = 17'd1 << 8;
    localparam logic [16:0] C_EO  = 17'd1 << 6;
    localparam logic [16:0] C_SU  = 17'd1 << 5;
    localparam logic [16:0] C_OI  = 17'd1 << 4;
    localparam logic [16:0] C_CE  = 17'd1 << 3;
    localparam logic [16:0] C_CO  = 17'd1 << 2;
    localparam logic [16:0] C_J   = 17'd1 << 1;
    localparam logic [16:0] C_FI  = 17'd1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] opcode = 4'b0010;
    logic       carry = 1'b0;
    logic       zero = 1'b0;
    logic HLT, MI, RI, RO, IO, II, AI, AO, BI, BO, EO, SU, OI, CE, CO, J, FI;
    logic [2:0] step;
    logic [1:0] flags;

    control_sequencer #(.STEPS(STEPS)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .carry(carry), .zero(zero),
        .HLT(HLT), .MI(MI), .RI(RI), .RO(RO), .IO(IO), .II(II),
        .AI(AI), .AO(AO), .BI(BI), .BO(BO), .EO(EO), .SU(SU),
        .OI(OI), .CE(CE), .CO(CO), .J(J), .FI(FI),
        .step(step), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] word;
        logic [2:0]  step;
        logic [1:0]  flags;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: microcode ROM plus instruction-level state
    logic [16:0] rom [16][8];
    int          m_step   = 0;
    logic [1:0]  m_flags  = 2'b00;
    bit          m_halted = 1'b0;

    function automatic void load_rom();
        for (int o = 0; o < 16; o++)
            for (int s = 0; s < 8; s++) rom[o][s] = '0;
        for (int o = 0; o < 16; o++) begin
            rom[o][0] = C_CO | C_MI;
            rom[o][1] = C_RO | C_II | C_CE;
        end
        rom[1][2]  = C_IO | C_MI;  rom[1][3] = C_RO | C_AI;
        rom[2][2]  = C_IO | C_MI;  rom[2][3] = C_RO | C_BI;  rom[2][4] = C_EO | C_AI | C_FI;
        rom[3][2]  = C_IO | C_MI;  rom[3][3] = C_RO | C_BI;  rom[3][4] = C_EO | C_AI | C_SU | C_FI;
        rom[4][2]  = C_IO | C_MI;  rom[4][3] = C_AO | C_RI;
        rom[5][2]  = C_IO | C_AI;
        rom[6][2]  = C_IO | C_J;
        rom[7][2]  = C_IO | C_J;   // taken only when C=1
        rom[8][2]  = C_IO | C_J;   // taken only when Z=1
        rom[14][2] = C_AO | C_OI;
        rom[15][2] = C_HLT;
    endfunction

    function automatic logic [16:0] model_word(logic r, logic [3:0] op);
        logic [16:0] w;
        if (!r) return '0;
        if (m_halted) return C_HLT;
        w = rom[op][m_step];
        if (m_step == 2 && op == 4'b0111 && !m_flags[1]) w = '0;
        if (m_step == 2 && op == 4'b1000 && !m_flags[0]) w = '0;
        return w;
    endfunction

    // One clock cycle: drive inputs, predict, then advance the model across the edge
    task automatic cycle(input logic r, input logic [3:0] op, input logic c, input logic z);
        exp_t        e;
        logic [16:0] w;
        @(posedge clk);
        #1;
        rst = r; opcode = op; carry = c; zero = z;
        w = model_word(r, op);
        e.word = w; e.step = 3'(m_step); e.flags = m_flags;
        exp_q.push_back(e);
        if (!r) begin
            m_step = 0; m_flags = 2'b00; m_halted = 1'b0;
        end else if (!m_halted) begin
            if ((w & C_FI) != '0) m_flags = {c, z};
            if ((w & C_HLT) != '0) m_halted = 1'b1;
            m_step = (m_step + 1) % STEPS;
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic c, input logic z, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, op, c, z);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest prediction
    always @(negedge clk) begin
        exp_t        e;
        logic [16:0] got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {HLT, MI, RI, RO, IO, II, AI, AO, BI, BO, EO, SU, OI, CE, CO, J, FI};
            n_tests += 3;
            if (got !== e.word) begin
                n_fail++;
                $display("FAIL ctrl_word t=%0t got=%b exp=%b", $time, got, e.word);
            end
            if (step !== e.step) begin
                n_fail++;
                $display("FAIL step t=%0t got=%0d exp=%0d", $time, step, e.step);
            end
            if (flags !== e.flags) begin
                n_fail++;
                $display("FAIL flags t=%0t got=%b exp=%b", $time, flags, e.flags);
            end
        end
    end

    initial begin
        logic [3:0] op;
        load_rom();
        repeat (2) @(posedge clk);

        // Reset held with ADD on the bus, then a full ADD setting C
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0010, 1'b0, 1'b0);
        run_instr(4'b0010, 1'b1, 1'b0, 5);
        run_instr(4'b0111, 1'b0, 1'b1, 5);   // JC taken
        run_instr(4'b1000, 1'b0, 1'b1, 5);   // JZ not taken
        run_instr(4'b0011, 1'b0, 1'b1, 5);   // SUB -> flags 01
        run_instr(4'b1000, 1'b1, 1'b0, 5);   // JZ taken
        run_instr(4'b0111, 1'b1, 1'b0, 5);   // JC not taken
        // Reset during STA step 3
        run_instr(4'b0100, 1'b0, 1'b0, 3);
        cycle(1'b0, 4'b0100, 1'b0, 1'b0);
        run_instr(4'b1011, 1'b1, 1'b1, 10);  // undefined opcode
        run_instr(4'b1111, 1'b0, 1'b0, 14);  // halt and stay halted
        cycle(1'b0, 4'b1111, 1'b0, 1'b0);
        run_instr(4'b0101, 1'b0, 1'b0, 5);

        // Randomized traffic; opcode only changes at step 0
        op = 4'b0000;
        for (int i = 0; i < 2000; i++) begin
            logic r;
            if (m_step == 0 && !m_halted) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'b1111 && $urandom_range(0, 3) != 0) op = 4'b0010;
            end
            r = !(($urandom_range(0, 63) == 0) || (m_halted && $urandom_range(0, 11) == 0));
            cycle(r, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcoded control unit for the 8-bit computer, sitting directly upstream of the ALU. It steps a 5-phase microinstruction counter and decodes the current opcode into the bus control word, including the ALU's AI/BI/AO/BO/EO/SU strobes. It holds the carry/zero flags register fed by the ALU flag outputs and uses the stored flags to resolve conditional jumps. All state is clocked; the control word is combinational from state and opcode.

## Interface
- STEPS, 5, microsteps per instruction; legal range 3..8; counter width is 3 bits.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- opcode  in  4  upper nibble of the instruction register.
- carry  in  1  ALU carry output.
- zero  in  1  ALU zero output.
- HLT  out  1  halt clock request.
- MI  out  1  memory address register in.
- RI  out  1  RAM in.
- RO  out  1  RAM out.
- IO  out  1  instruction register low nibble out.
- II  out  1  instruction register in.
- AI, AO, BI, BO, EO, SU  out  1 each  ALU register and adder strobes. BO is always 0 in this microcode.
- OI  out  1  output register in.
- CE  out  1  program counter enable.
- CO  out  1  program counter out.
- J  out  1  program counter load (jump).
- FI  out  1  flags register load.
- step  out  3  current microstep, for debug.
- flags  out  2  stored flags {C,Z}.

## Operation
- **State:** `step` (0..STEPS-1), `flags` {C,Z}, and a `halted` bit.
- **Step counter:** while not halted, `step` increments each cycle and wraps from STEPS-1 to 0. There is no early termination; unused steps emit an all-zero control word.
- **Fetch, all opcodes:**
  - step0: CO MI.
  - step1: RO II CE.
- **Execute, steps 2 onward:**
  - 0000 NOP: none.
  - 0001 LDA: s2 IO MI; s3 RO AI.
  - 0010 ADD: s2 IO MI; s3 RO BI; s4 EO AI FI.
  - 0011 SUB: s2 IO MI; s3 RO BI; s4 EO AI SU FI.
  - 0100 STA: s2 IO MI; s3 AO RI.
  - 0101 LDI: s2 IO AI.
  - 0110 JMP: s2 IO J.
  - 0111 JC: s2 IO J if C=1, otherwise none.
  - 1000 JZ: s2 IO J if Z=1, otherwise none.
  - 1110 OUT: s2 AO OI.
  - 1111 HLT: s2 HLT.
  - All other opcodes behave as NOP.
- **Flags:** when FI=1 in a cycle, {C,Z} ← {carry, zero} at that rising edge. Otherwise the flags hold. Conditional jumps use the stored flags, never the live ALU outputs.
- **Halt:** a cycle with HLT=1 at step 2 sets `halted`. While halted:
  - HLT=1 and every other control output is 0.
  - `step` and `flags` are frozen.
  - Only reset exits the halted state.
- **Reset (rst=0 at an edge):** step ← 0, flags ← 00, halted ← 0.
  - While rst=0, all control outputs are forced to 0 combinationally.
  - Reset takes effect mid-instruction regardless of step or halt state.
  - The first cycle after release is step0 of a fresh fetch.
- **STEPS<5:** steps at or beyond STEPS are never reached. ADD and SUB are then incomplete; this is the integrator's responsibility.

## Timing
- Control outputs are combinational from (step, opcode, flags, halted, rst) and are valid within the same cycle the step is entered.
- Instruction period is exactly STEPS cycles.
- Flag update latency: a flag written at an ADD s4 edge is visible to a JC/JZ at s2 of the next instruction.
- FI and a flag read never coincide within one instruction.
- The opcode input must be stable from the step1 edge (II) through the last step.
- Step sequence after reset release: 0,1,2,3,4,0,…
- HLT asserts in the step-2 cycle and then stays high from the following cycle onward.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with opcode=0010 → all outputs 0, step=0, flags=00. Release → step0 word is CO MI, then RO II CE.
- **ADD and flags:** opcode=0010 with carry=1, zero=0 → s2 IO MI; s3 RO BI; s4 EO AI FI; flags=10 after the s4 edge.
- **Conditional jumps:** with flags=10, JC gives J=1 at s2 and JZ gives J=0. After a SUB with carry=0, zero=1 (flags=01), JZ gives J=1 and JC gives J=0.
- **Halt:** opcode=1111 → HLT=1 at s2 and all later cycles; step stays at 3 for 10 cycles; all other outputs stay 0. Pulsing rst=0 restores fetch.
- **Reset mid-instruction:** rst=0 during s3 of STA (AO RI) → outputs go to 0 immediately; step=0 on the next cycle; flags are cleared.
- **Undefined opcode:** opcode 1011 → only the fetch words appear, steps 2–4 are all zero, and the wrap to step0 occurs after 5 cycles.
